// File: rtl/support_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : support_mem_loader
//  Description : Streams host bytes into support RAM via its system write port,
//                arbitrating with the support CPU by request/grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module support_mem_loader #(
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        cmd_abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        cpu_req,
    input  logic        cpu_grant,
    output logic        sys_en,
    output logic [15:0] sys_A,
    output logic [7:0]  sys_data,
    output logic        sys_wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] remaining
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_req   = 2'd1;
    localparam logic [1:0]  c_st_xfer  = 2'd2;
    localparam logic [1:0]  c_st_drain = 2'd3;
    localparam logic [15:0] c_timeout_last = 16'(GRANT_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [15:0] r_addr;
    logic [15:0] r_remaining;
    logic [15:0] r_timer;
    logic        r_owned;
    logic [15:0] r_sys_a;
    logic [7:0]  r_sys_data;
    logic        r_sys_wr;
    logic        r_done;
    logic        r_error;

    logic        w_accept;

    assign s_ready   = (r_state == c_st_xfer) && (r_remaining != 16'd0) && !cmd_abort;
    assign w_accept  = s_valid && s_ready;
    assign cpu_req   = (r_state != c_st_idle);
    assign busy      = (r_state != c_st_idle);
    // DRAIN keeps the mux only if the bus was actually granted, so a timeout
    // never drives the RAM port.
    assign sys_en    = (r_state == c_st_xfer) || ((r_state == c_st_drain) && r_owned);
    assign sys_A     = r_sys_a;
    assign sys_data  = r_sys_data;
    assign sys_wr    = r_sys_wr;
    assign done      = r_done;
    assign error     = r_error;
    assign remaining = r_remaining;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_addr      <= 16'd0;
            r_remaining <= 16'd0;
            r_timer     <= 16'd0;
            r_owned     <= 1'b0;
            r_sys_a     <= 16'd0;
            r_sys_data  <= 8'd0;
            r_sys_wr    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_sys_wr <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_owned <= 1'b0;
                    if (cmd_start) begin
                        r_error <= 1'b0;
                        if (cmd_len != 16'd0) begin
                            r_addr      <= cmd_addr;
                            r_remaining <= cmd_len;
                            r_timer     <= 16'd0;
                            r_state     <= c_st_req;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_req: begin
                    if (cmd_abort) begin
                        r_error <= 1'b1;
                        r_state <= c_st_drain;
                    end else if (cpu_grant) begin
                        r_owned <= 1'b1;
                        r_state <= c_st_xfer;
                    end else if (r_timer == c_timeout_last) begin
                        r_error <= 1'b1;
                        r_state <= c_st_drain;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                c_st_xfer: begin
                    // s_ready already excludes cmd_abort, so accept and abort
                    // are mutually exclusive here.
                    if (w_accept) begin
                        r_sys_wr    <= 1'b1;
                        r_sys_a     <= r_addr;
                        r_sys_data  <= s_data;
                        r_addr      <= r_addr + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= c_st_drain;
                        end
                    end else if (cmd_abort) begin
                        r_error <= 1'b1;
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    r_done      <= 1'b1;
                    r_remaining <= 16'd0;
                    r_owned     <= 1'b0;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_support_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_support_mem_loader
//  Description : Scoreboard bench for support_mem_loader: expected RAM writes
//                and done/error results are queued and checked by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_support_mem_loader;

    localparam int c_gt = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [15:0] cmd_addr = 16'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        cmd_abort = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        cpu_req;
    logic        cpu_grant = 1'b0;
    logic        sys_en;
    logic [15:0] sys_A;
    logic [7:0]  sys_data;
    logic        sys_wr;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] remaining;

    support_mem_loader #(.GRANT_TIMEOUT(c_gt)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_abort (cmd_abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .cpu_req   (cpu_req),
        .cpu_grant (cpu_grant),
        .sys_en    (sys_en),
        .sys_A     (sys_A),
        .sys_data  (sys_data),
        .sys_wr    (sys_wr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_err[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_count = 0;
    int first_wr = -1;
    int last_wr = -1;
    int done_count = 0;
    int done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endfunction

    // Monitor: every RAM write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        wr_t  e;
        logic ee;
        if (reset_n) begin
            if (sys_wr) begin
                chk("wr_sys_en", 64'(sys_en), 64'd1);
                if (exp_wr.size() == 0) begin
                    fail_now("wr_unexpected");
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(sys_A), 64'(e.a));
                    chk("wr_data", 64'(sys_data), 64'(e.d));
                end
                wr_count++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (done) begin
                if (exp_err.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    ee = exp_err.pop_front();
                    chk("done_error", 64'(error), 64'(ee));
                end
                chk("done_cpu_req", 64'(cpu_req), 64'd0);
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wr_count = 0;
        first_wr = -1;
        last_wr = -1;
        done_count = 0;
        done_cyc = -1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic start_cmd(input logic [15:0] a, input logic [15:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Presents one byte after `gap` idle cycles and returns after it is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        logic ok;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) tick();
        end
        s_valid = 1'b1;
        s_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            tick();
        end
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic wait_done(input int max);
        int d0;
        d0 = done_count;
        for (int i = 0; i < max && done_count == d0; i++) tick();
        if (done_count == d0) fail_now("done_timeout");
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) tick();
        chk("reset_outputs",
            64'({s_ready, cpu_req, sys_en, sys_A, sys_data, sys_wr, busy, done, error, remaining}),
            64'd0);
        reset_n = 1'b1;
        tick();

        // Contiguous load with grant after 3 cycles
        clear_stats();
        push_wr(16'h8000, 8'hA1);
        push_wr(16'h8001, 8'hA2);
        push_wr(16'h8002, 8'hA3);
        push_wr(16'h8003, 8'hA4);
        exp_err.push_back(1'b0);
        start_cmd(16'h8000, 16'd4);
        chk("req_state", 64'({busy, cpu_req, sys_en}), 64'b110);
        chk("req_remaining", 64'(remaining), 64'd4);
        repeat (3) tick();
        cpu_grant = 1'b1;
        send(8'hA1, 0);
        send(8'hA2, 0);
        send(8'hA3, 0);
        send(8'hA4, 0);
        s_valid = 1'b0;
        wait_done(20);
        chk("t1_wr_count", 64'(wr_count), 64'd4);
        chk("t1_consecutive", 64'(last_wr - first_wr), 64'd3);
        chk("t1_done_lat", 64'(done_cyc - last_wr), 64'd1);
        chk("t1_idle", 64'({busy, cpu_req, sys_en, remaining}), 64'd0);
        cpu_grant = 1'b0;
        tick();

        // Wrap-around with gaps in the stream
        clear_stats();
        push_wr(16'hFFFE, 8'h01);
        push_wr(16'hFFFF, 8'h02);
        push_wr(16'h0000, 8'h03);
        push_wr(16'h0001, 8'h04);
        exp_err.push_back(1'b0);
        start_cmd(16'hFFFE, 16'd4);
        cpu_grant = 1'b1;
        send(8'h01, 2);
        send(8'h02, 0);
        send(8'h03, 3);
        send(8'h04, 1);
        s_valid = 1'b0;
        wait_done(20);
        chk("t2_wr_count", 64'(wr_count), 64'd4);
        cpu_grant = 1'b0;
        tick();

        // Grant timeout: 8 cycles in REQ plus the DRAIN cycle
        clear_stats();
        exp_err.push_back(1'b1);
        start_cmd(16'h1234, 16'd5);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!cpu_req) break;
            n++;
        end
        chk("t3_req_cycles", 64'(n), 64'd9);
        chk("t3_error", 64'(error), 64'd1);
        tick();
        chk("t3_wr_count", 64'(wr_count), 64'd0);
        chk("t3_done_count", 64'(done_count), 64'd1);
        chk("t3_error_sticky", 64'(error), 64'd1);

        // Abort after 5th accepted byte of 16
        clear_stats();
        for (int i = 0; i < 5; i++) push_wr(16'h0100 + 16'(i), 8'h10 + 8'(i));
        exp_err.push_back(1'b1);
        start_cmd(16'h0100, 16'd16);
        chk("t4_error_cleared", 64'(error), 64'd0);
        cpu_grant = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 0);
        cmd_abort = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'h15;
        @(negedge clk);
        chk("t4_s_ready_abort", 64'(s_ready), 64'd0);
        chk("t4_remaining", 64'(remaining), 64'd11);
        tick();
        cmd_abort = 1'b0;
        s_valid   = 1'b0;
        wait_done(20);
        chk("t4_wr_count", 64'(wr_count), 64'd5);
        chk("t4_error", 64'(error), 64'd1);
        cpu_grant = 1'b0;
        tick();

        // Zero-length command
        clear_stats();
        exp_err.push_back(1'b0);
        start_cmd(16'h5555, 16'd0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_quiet", 64'({cpu_req, busy, error}), 64'd0);
        tick();
        chk("t5_done_pulse", 64'(done), 64'd0);

        // cmd_start while busy has no effect
        clear_stats();
        push_wr(16'h1000, 8'h31);
        push_wr(16'h1001, 8'h32);
        exp_err.push_back(1'b0);
        start_cmd(16'h1000, 16'd2);
        tick();
        start_cmd(16'h2000, 16'd9);
        chk("t5_busy_remaining", 64'(remaining), 64'd2);
        cpu_grant = 1'b1;
        send(8'h31, 0);
        send(8'h32, 0);
        s_valid = 1'b0;
        wait_done(20);
        chk("t5_wr_count", 64'(wr_count), 64'd2);
        cpu_grant = 1'b0;
        tick();

        // Asynchronous reset in the middle of a transfer
        clear_stats();
        push_wr(16'h4000, 8'h41);
        push_wr(16'h4001, 8'h42);
        push_wr(16'h4002, 8'h43);
        start_cmd(16'h4000, 16'd8);
        cpu_grant = 1'b1;
        send(8'h41, 0);
        send(8'h42, 0);
        send(8'h43, 0);
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_now", 64'({sys_en, sys_wr, cpu_req, busy}), 64'd0);
        s_valid = 1'b1;
        s_data  = 8'h44;
        repeat (3) tick();
        chk("t6_no_more_wr", 64'(wr_count), 64'd3);
        chk("t6_held_reset", 64'({sys_en, sys_wr, cpu_req, busy, remaining}), 64'd0);
        s_valid   = 1'b0;
        cpu_grant = 1'b0;
        reset_n   = 1'b1;
        repeat (2) tick();

        chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("exp_err_drained", 64'(exp_err.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
